imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL expose: clk  in  1  single clock; all state updates on rising edge.
REQ-002 The block SHALL expose: reset  in  1  synchronous, active-high reset.
REQ-003 The block SHALL expose: in_valid  in  1  request carries a 32-bit constant to encode.
REQ-004 The block SHALL expose: in_ready  out  1  block can accept a request.
REQ-005 The block SHALL expose: value  in  32  constant to be encoded as an ARM rotated immediate.
REQ-006 The block SHALL expose: out_valid  out  1  result fields are valid.
REQ-007 The block SHALL expose: out_ready  in  1  consumer accepts the result.
REQ-008 The block SHALL expose: found  out  1  an encoding exists.
REQ-009 The block SHALL expose: rot  out  4  rotate field; decoded value = ROR(zero-extended imm8, 2*rot).
REQ-010 The block SHALL expose: imm8  out  8  immediate field.
REQ-011 The block SHALL expose: src2  out  12  {rot, imm8}, the Instr[11:0] operand-2 field.
REQ-012 The block SHALL expose: inverted  out  1  the encoding is of ~value (MVN/BIC form); constant 0 without IMM_ENC_INVERT_EN.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, SEARCH and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted on an edge where in_valid and in_ready are both 1.
REQ-015 Acceptance SHALL latch value into an internal register, clear rot counter r to 0, clear pass to 0 and move to SEARCH.
REQ-016 In SEARCH, each cycle SHALL test candidate c = ROL(operand, 2*r), where operand is the latched value, or its complement when pass=1.
REQ-017 A hit (c[31:8]==0) SHALL register found=1, rot=r, imm8=c[7:0] and inverted=pass, then move to DONE.
REQ-018 On a miss with r<15, r SHALL increment; rotations are tested in ascending order, so the smallest valid rot is always reported.
REQ-019 On a miss at r=15, the final pass SHALL register found=0, rot=0, imm8=0 and inverted=0, then move to DONE.
REQ-020 Latency: with the acceptance edge as E0, a hit at rot k on pass p SHALL raise out_valid after edge E(16p+k+1); a total miss SHALL raise out_valid after E16, or E32 with the feature enabled.
REQ-021 In DONE, out_valid SHALL be 1 and all result fields SHALL be held stable until the edge where out_ready=1, which returns the FSM to IDLE.
REQ-022 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-023 A new request SHALL NOT be accepted on the same edge as a DONE->IDLE transition; the earliest next acceptance is one cycle later.
REQ-024 value=0 SHALL encode as found=1, rot=0, imm8=0 after E1.
REQ-025 Changes on value after acceptance SHALL NOT affect the result in progress.

Reset
REQ-026 When reset=1 on an edge, the state SHALL become IDLE, r=0, pass=0 and all outputs SHALL be 0 except in_ready=1; this takes priority over every other event.
REQ-027 Reset asserted mid-SEARCH or in DONE SHALL discard the request, and no out_valid SHALL follow for it.

Configuration
REQ-028 With macro IMM_ENC_INVERT_EN defined, a pass-0 miss at r=15 SHALL set pass=1 and r=0 and continue SEARCH on ~value; the total-miss result then occurs at the end of pass 1.
REQ-029 Without IMM_ENC_INVERT_EN, only pass 0 SHALL exist, inverted SHALL be tied to 0, and the pass register SHALL be omitted.

Verification
REQ-030 The bench SHALL cover: value=0x000000FF -> found=1, rot=0, imm8=0xFF, src2=0x0FF, out_valid after E1.
REQ-031 The bench SHALL cover: value=0xFF000000 -> found=1, rot=4, imm8=0xFF, src2=0x4FF, out_valid after E5.
REQ-032 The bench SHALL cover: value=0x00000104 -> found=1, rot=15, imm8=0x41, src2=0xF41, out_valid after E16.
REQ-033 The bench SHALL cover: value=0xFFFFFF00 -> without macro, found=0 after E16; with IMM_ENC_INVERT_EN, found=1, inverted=1, rot=0, imm8=0xFF after E17.
REQ-034 The bench SHALL cover: value=0x00000101 with out_ready held 0 for 5 cycles -> found=0 with out_valid high and fields stable throughout; with the macro, out_valid rises after E32.
REQ-035 The bench SHALL cover: reset pulsed at E3 of the 0x00000104 search -> in_ready=1 and out_valid=0 after that edge; a following 0x000000FF request completes normally.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: finds the ARM rotated-immediate encoding of a 32-bit constant, one rotation per cycle.
// Define IMM_ENC_INVERT_EN to also search ~value (MVN/BIC form) after a failed first pass.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        found,
    output logic [3:0]  rot,
    output logic [7:0]  imm8,
    output logic [11:0] src2,
    output logic        inverted
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [3:0]  r_q, r_d, rot_q, rot_d;
    logic [7:0]  imm8_q, imm8_d;
    logic        found_q, found_d;
    logic [31:0] operand;
    logic [63:0] dbl;
    logic [31:0] cand;
    logic        hit;

`ifdef IMM_ENC_INVERT_EN
    logic pass_q, pass_d, inv_q, inv_d;
    assign operand  = pass_q ? ~value_q : value_q;
    assign inverted = inv_q;
`else
    assign operand  = value_q;
    assign inverted = 1'b0;
`endif

    // Upper half of the doubled word shifted left is ROL(operand, 2*r), safe at r=0.
    assign dbl  = {operand, operand} << {r_q, 1'b0};
    assign cand = dbl[63:32];
    assign hit  = cand[31:8] == 24'd0;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign found     = found_q;
    assign rot       = rot_q;
    assign imm8      = imm8_q;
    assign src2      = {rot_q, imm8_q};

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        r_d     = r_q;
        rot_d   = rot_q;
        imm8_d  = imm8_q;
        found_d = found_q;
`ifdef IMM_ENC_INVERT_EN
        pass_d  = pass_q;
        inv_d   = inv_q;
`endif
        if (state_q == IDLE && in_valid) begin
            value_d = value;
            r_d     = 4'd0;
`ifdef IMM_ENC_INVERT_EN
            pass_d  = 1'b0;
`endif
            state_d = SEARCH;
        end else if (state_q == SEARCH) begin
            if (hit) begin
                found_d = 1'b1;
                rot_d   = r_q;
                imm8_d  = cand[7:0];
`ifdef IMM_ENC_INVERT_EN
                inv_d   = pass_q;
`endif
                state_d = DONE;
            end else if (r_q != 4'd15) begin
                r_d = r_q + 4'd1;
`ifdef IMM_ENC_INVERT_EN
            end else if (!pass_q) begin
                pass_d = 1'b1;
                r_d    = 4'd0;
`endif
            end else begin
                found_d = 1'b0;
                rot_d   = 4'd0;
                imm8_d  = 8'd0;
`ifdef IMM_ENC_INVERT_EN
                inv_d   = 1'b0;
`endif
                state_d = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            value_q <= 32'd0;
            r_q     <= 4'd0;
            rot_q   <= 4'd0;
            imm8_q  <= 8'd0;
            found_q <= 1'b0;
`ifdef IMM_ENC_INVERT_EN
            pass_q  <= 1'b0;
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            r_q     <= r_d;
            rot_q   <= rot_d;
            imm8_q  <= imm8_d;
            found_q <= found_d;
`ifdef IMM_ENC_INVERT_EN
            pass_q  <= pass_d;
            inv_q   <= inv_d;
`endif
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: vector table plus scoreboard queue for imm_encoder, with a mid-search reset sequence.
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] value = 32'd0;
    logic        in_ready, out_valid, found, inverted;
    logic [3:0]  rot;
    logic [7:0]  imm8;
    logic [11:0] src2;

    imm_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .value(value),
        .out_valid(out_valid), .out_ready(out_ready), .found(found), .rot(rot), .imm8(imm8),
        .src2(src2), .inverted(inverted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic        f;
        logic [3:0]  rot;
        logic [7:0]  imm;
        logic        inv;
        int          lat;
        int          hold;
        logic        noise;
    } vec_t;

    typedef struct {
        logic       f;
        logic [3:0] rot;
        logic [7:0] imm;
        logic       inv;
        int         lat;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t t);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1'b1;
        value    = t.v;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid  = t.noise;
        value     = ~t.v;
        out_ready = t.noise;
        sb.push_back('{t.f, t.rot, t.imm, t.inv, t.lat});
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            chk("timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            in_valid = 1'b0;
            out_ready = 1'b0;
            return;
        end
        e = sb.pop_front();
        chk("latency", n, e.lat);
        out_ready = (t.hold == 0);
        for (int i = 0; i <= t.hold; i++) begin
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("found", {31'd0, found}, {31'd0, e.f});
            chk("rot", {28'd0, rot}, {28'd0, e.rot});
            chk("imm8", {24'd0, imm8}, {24'd0, e.imm});
            chk("src2", {20'd0, src2}, {20'd0, e.rot, e.imm});
            chk("inverted", {31'd0, inverted}, {31'd0, e.inv});
            if (i < t.hold) begin
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        chk("done_to_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("no_accept_on_release", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        vecs[0] = '{32'h000000FF, 1'b1, 4'd0,  8'hFF, 1'b0, 1,  0, 1'b0};
        vecs[1] = '{32'hFF000000, 1'b1, 4'd4,  8'hFF, 1'b0, 5,  0, 1'b1};
        vecs[2] = '{32'h00000104, 1'b1, 4'd15, 8'h41, 1'b0, 16, 0, 1'b0};
        vecs[3] = '{32'h00000000, 1'b1, 4'd0,  8'h00, 1'b0, 1,  0, 1'b0};
`ifdef IMM_ENC_INVERT_EN
        vecs[4] = '{32'hFFFFFF00, 1'b1, 4'd0,  8'hFF, 1'b1, 17, 0, 1'b0};
        vecs[5] = '{32'h00000101, 1'b0, 4'd0,  8'h00, 1'b0, 32, 5, 1'b0};
`else
        vecs[4] = '{32'hFFFFFF00, 1'b0, 4'd0,  8'h00, 1'b0, 16, 0, 1'b0};
        vecs[5] = '{32'h00000101, 1'b0, 4'd0,  8'h00, 1'b0, 16, 5, 1'b0};
`endif
        vecs[6] = '{32'h000FF000, 1'b1, 4'd10, 8'hFF, 1'b0, 11, 2, 1'b1};
        vecs[7] = '{32'hF000000F, 1'b1, 4'd2,  8'hFF, 1'b0, 3,  0, 1'b0};
        vecs[8] = '{32'h80000000, 1'b1, 4'd1,  8'h02, 1'b0, 2,  1, 1'b1};
        vecs[9] = '{32'h00000100, 1'b1, 4'd12, 8'h01, 1'b0, 13, 0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fields", {19'd0, found, src2, inverted}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run(vecs[i]);

        // Reset lands on E3 of a long search: the request must vanish.
        @(negedge clk);
        in_valid = 1'b1;
        value    = 32'h00000104;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_fields", {19'd0, found, src2, inverted}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_result", seen, 0);
        run(vecs[0]);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
